// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller.
// Takes the EX/MEM pipeline register outputs and runs one load or store at a
// time over a variable-latency request/ack data-memory port. It produces the
// registered MEM/WB write-back fields, and holds the earlier pipeline stages
// with `stall` while a memory operation is outstanding.
// Optional build macro: MEM_TIMEOUT_EN. When it is defined, an ACCESS that
// receives no ack within TIMEOUT cycles is abandoned. The abandoned access
// returns 32'hDEADBEEF as read data, suppresses its write-back and sets the
// sticky mem_err flag.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] aLUOut,
    input  logic [31:0] read_data2,
    input  logic [4:0]  regWrAddr,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memtoReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_regWrAddr,
    output logic        wb_regWrite,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // The memory is word addressed; the byte offset is dropped without a trap.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t      state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_regWrAddr_q, wb_regWrAddr_d;
    logic        wb_regWrite_q, wb_regWrite_d;
    logic        acc_s;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             mem_err_q, mem_err_d;
`endif

    // A load wins when both read and write are requested.
    assign acc_s = memRead | memWrite;

    // Next-state and next-register computation for the MEM stage.
    always_comb begin
        state_d        = state_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_wdata_d   = dmem_wdata_q;
        rdata_d        = rdata_q;
        wb_data_d      = wb_data_q;
        wb_regWrAddr_d = wb_regWrAddr_q;
        wb_regWrite_d  = wb_regWrite_q;
        stall          = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d          = cnt_q;
        timeout_d      = timeout_q;
        mem_err_d      = mem_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    stall         = 1'b1;
                    state_d       = ST_ACCESS;
                    dmem_req_d    = 1'b1;
                    dmem_we_d     = memWrite & ~memRead;
                    dmem_addr_d   = word_align(aLUOut);
                    dmem_wdata_d  = read_data2;
                    wb_regWrite_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d         = {CNT_W{1'b0}};
                    timeout_d     = 1'b0;
`endif
                end else begin
                    wb_data_d      = aLUOut;
                    wb_regWrAddr_d = regWrAddr;
                    wb_regWrite_d  = regWrite;
                end
            end
            ST_ACCESS: begin
                stall         = 1'b1;
                wb_regWrite_d = 1'b0;
                if (dmem_ack) begin
                    rdata_d    = dmem_rdata;
                    dmem_req_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    // The cycle that brings the wait count up to TIMEOUT ends the access.
                    if ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT)) begin
                        dmem_req_d = 1'b0;
                        rdata_d    = 32'hDEADBEEF;
                        timeout_d  = 1'b1;
                        mem_err_d  = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
`else
                    state_d = ST_ACCESS;
`endif
                end
            end
            ST_DONE: begin
                state_d        = ST_IDLE;
                wb_data_d      = memtoReg ? rdata_q : aLUOut;
                wb_regWrAddr_d = regWrAddr;
`ifdef MEM_TIMEOUT_EN
                wb_regWrite_d  = regWrite & ~timeout_q;
                timeout_d      = 1'b0;
`else
                wb_regWrite_d  = regWrite;
`endif
            end
            default: begin
                state_d    = ST_IDLE;
                dmem_req_d = 1'b0;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= 32'd0;
            dmem_wdata_q   <= 32'd0;
            rdata_q        <= 32'd0;
            wb_data_q      <= 32'd0;
            wb_regWrAddr_q <= 5'd0;
            wb_regWrite_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wdata_q   <= dmem_wdata_d;
            rdata_q        <= rdata_d;
            wb_data_q      <= wb_data_d;
            wb_regWrAddr_q <= wb_regWrAddr_d;
            wb_regWrite_q  <= wb_regWrite_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Timeout counter and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign dmem_req     = dmem_req_q;
    assign dmem_we      = dmem_we_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign wb_data      = wb_data_q;
    assign wb_regWrAddr = wb_regWrAddr_q;
    assign wb_regWrite  = wb_regWrite_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage.
// The expected values come from a transaction-level model kept in the driver
// tasks. A non-memory op retires on the next edge. A memory op stalls for one
// issue cycle plus its ACCESS cycles, and then retires one cycle after the ack.
// A compare process checks every output against that model on each falling edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aLUOut, read_data2, dmem_addr, dmem_wdata, dmem_rdata, wb_data;
    logic [4:0]  regWrAddr, wb_regWrAddr;
    logic        regWrite, memRead, memWrite, memtoReg;
    logic        dmem_req, dmem_we, dmem_ack, stall, wb_regWrite, mem_err;

    int n_vec = 0;
    int n_err = 0;
    int stall_cnt = 0;
    int req_rises = 0;
    int cyc = 0;
    logic req_prev = 1'b0;
    logic check_en = 1'b0;

    logic        exp_stall, exp_req, exp_we, exp_rw, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_wb_data;
    logic [4:0]  exp_rd;

`ifdef MEM_TIMEOUT_EN
    mem_access_stage #(.TIMEOUT(4)) dut (
`else
    mem_access_stage dut (
`endif
        .clk(clk), .reset(reset), .aLUOut(aLUOut), .read_data2(read_data2),
        .regWrAddr(regWrAddr), .regWrite(regWrite), .memRead(memRead),
        .memWrite(memWrite), .memtoReg(memtoReg), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .wb_data(wb_data), .wb_regWrAddr(wb_regWrAddr), .wb_regWrite(wb_regWrite),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("stall",        32'(stall),        32'(exp_stall));
            chk("dmem_req",     32'(dmem_req),     32'(exp_req));
            chk("dmem_we",      32'(dmem_we),      32'(exp_we));
            chk("dmem_addr",    dmem_addr,         exp_addr);
            chk("dmem_wdata",   dmem_wdata,        exp_wdata);
            chk("wb_data",      wb_data,           exp_wb_data);
            chk("wb_regWrAddr", 32'(wb_regWrAddr), 32'(exp_rd));
            chk("wb_regWrite",  32'(wb_regWrite),  32'(exp_rw));
            chk("mem_err",      32'(mem_err),      32'(exp_err));
            if (stall) stall_cnt++;
            if (dmem_req && !req_prev) req_rises++;
            req_prev = dmem_req;
            cyc++;
        end
    end

    task automatic set_in(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        aLUOut = alu; read_data2 = rd2; regWrAddr = rd; regWrite = rw;
        memRead = mr; memWrite = mw; memtoReg = m2r;
    endtask

    // One EX/MEM instruction. A memory op gets waitc cycles without ack, then an ack with rdata.
    task automatic run_instr(input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic mw, input logic m2r,
                             input int waitc, input logic [31:0] rdata);
        set_in(alu, rd2, rd, rw, mr, mw, m2r);
        exp_stall = mr | mw;
        @(posedge clk); #1;
        if (!(mr | mw)) begin
            exp_wb_data = alu; exp_rd = rd; exp_rw = rw;
        end else begin
            exp_req = 1'b1; exp_we = mw & ~mr;
            exp_addr = alu & 32'hFFFF_FFFC; exp_wdata = rd2; exp_rw = 1'b0;
            for (int i = 0; i < waitc; i++) begin
                @(posedge clk); #1;
            end
            dmem_ack = 1'b1; dmem_rdata = rdata;
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
            exp_req = 1'b0; exp_stall = 1'b0;
            @(posedge clk); #1;
            exp_wb_data = m2r ? rdata : alu; exp_rd = rd; exp_rw = rw;
        end
    endtask

    task automatic exp_zero();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0;
        exp_wb_data = 32'd0; exp_rd = 5'd0; exp_rw = 1'b0; exp_err = 1'b0;
    endtask

    initial begin
        int c0;
        reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_zero();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_en = 1'b1;
        @(posedge clk); #1;
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_req", 32'(dmem_req), 32'd0);

        // Reset in the middle of an ACCESS, followed by a late ack.
        set_in(32'h0000_0500, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h500; exp_wdata = 32'd0; exp_rw = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b0; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_zero();
        check_en = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_req", 32'(dmem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        chk("late_ack_addr", dmem_addr, 32'd0);

        // ALU pass-through.
        stall_cnt = 0;
        run_instr(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        chk("alu_wb_data", wb_data, 32'h0000_1234);
        chk("alu_wb_rd", 32'(wb_regWrAddr), 32'd5);
        chk("alu_wb_rw", 32'(wb_regWrite), 32'd1);
        chk("alu_stall_cnt", 32'(stall_cnt), 32'd0);

        // Load with an ack on the third ACCESS cycle.
        stall_cnt = 0;
        run_instr(32'h0000_0104, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 2, 32'hCAFE_F00D);
        chk("ld_addr", dmem_addr, 32'h0000_0104);
        chk("ld_we", 32'(dmem_we), 32'd0);
        chk("ld_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("ld_wb_data", wb_data, 32'hCAFE_F00D);
        chk("ld_wb_rw", 32'(wb_regWrite), 32'd1);

        // Misaligned store with a zero-wait ack.
        stall_cnt = 0;
        run_instr(32'h0000_0203, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h7777_7777);
        chk("st_addr", dmem_addr, 32'h0000_0200);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk("st_stall_cnt", 32'(stall_cnt), 32'd2);
        chk("st_wb_rw", 32'(wb_regWrite), 32'd0);

        // Back-to-back load then store.
        stall_cnt = 0; req_rises = 0; c0 = cyc;
        run_instr(32'h0000_0300, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 0, 32'h1111_2222);
        chk("b2b_ld_wb", wb_data, 32'h1111_2222);
        run_instr(32'h0000_0404, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'd0);
        chk("b2b_cycles", 32'(cyc - c0), 32'd6);
        chk("b2b_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("b2b_req_rises", 32'(req_rises), 32'd2);
        chk("b2b_st_wb", wb_data, 32'h0000_0404);

        // A load with both read and write set is a load; its address is aligned.
        run_instr(32'h0000_0A0E, 32'h0000_00FF, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1, 32'h0BEE_F123);
        chk("both_we", 32'(dmem_we), 32'd0);
        chk("both_addr", dmem_addr, 32'h0000_0A0C);

`ifdef MEM_TIMEOUT_EN
        // No ack: the access is abandoned after four ACCESS cycles.
        set_in(32'h0000_0800, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        exp_stall = 1'b1;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h800; exp_wdata = 32'd0; exp_rw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        exp_req = 1'b0; exp_err = 1'b1; exp_stall = 1'b0;
        @(posedge clk); #1;
        exp_wb_data = 32'hDEAD_BEEF; exp_rd = 5'd7; exp_rw = 1'b0;
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_wb_rw", 32'(wb_regWrite), 32'd0);
        run_instr(32'h0000_0042, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0);
        chk("to_err_sticky", 32'(mem_err), 32'd1);
`else
        // Without the timeout, a long wait still completes and no error is raised.
        run_instr(32'h0000_0900, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 20, 32'h2468_ACE0);
        chk("long_wb_data", wb_data, 32'h2468_ACE0);
        chk("long_err", 32'(mem_err), 32'd0);
`endif

        set_in(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        exp_wb_data = 32'd0; exp_rd = 5'd0; exp_rw = 1'b0;
        @(posedge clk); #1;
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller; consumes the EX/MEM pipeline register outputs and drives a variable-latency data-memory request/ack interface.
- Produces the registered MEM/WB fields: write-back data, destination register and write enable.
- Asserts `stall` to hold the EX/MEM register and all earlier stages while a load or store is outstanding.

Parameters:
- `TIMEOUT`, 255, max cycles spent in ACCESS waiting for `dmem_ack`. Used only with `MEM_TIMEOUT_EN`.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-low reset.
- `aLUOut` input 32: EX/MEM ALU result; memory address or write-back value.
- `read_data2` input 32: EX/MEM store data.
- `regWrAddr` input 5: EX/MEM destination register.
- `regWrite` input 1: EX/MEM register write enable.
- `memRead` input 1: EX/MEM load request.
- `memWrite` input 1: EX/MEM store request.
- `memtoReg` input 1: selects memory data for write-back.
- `dmem_req` output 1: memory request, registered.
- `dmem_we` output 1: 1 = store, 0 = load.
- `dmem_addr` output 32: word-aligned address.
- `dmem_wdata` output 32: store data.
- `dmem_ack` input 1: one-cycle completion pulse.
- `dmem_rdata` input 32: load data, valid with `dmem_ack`.
- `stall` output 1: holds EX/MEM and earlier stages, combinational.
- `wb_data` output 32: MEM/WB write-back data.
- `wb_regWrAddr` output 5: MEM/WB destination register.
- `wb_regWrite` output 1: MEM/WB write enable.
- `mem_err` output 1: sticky timeout error.

Behaviour:
- **Clock/reset:** one clock `clk`; `reset` is synchronous and active-low.
- **Reset** (`reset`=0 at a rising edge):
  - state=IDLE.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `wb_data`, `wb_regWrAddr`, `wb_regWrite`, `mem_err`, latched read data all 0.
  - Reset applies in any state. An in-flight request is abandoned; a later `dmem_ack` is ignored in IDLE.
- **States:** IDLE, ACCESS, DONE.
- **Access detection:** `acc` = `memRead` | `memWrite`. If both are set, treat as a load (`memRead` has priority).
- **IDLE, `acc`=0** (pass-through):
  - `stall`=0.
  - Next edge: `wb_data`←`aLUOut`, `wb_regWrAddr`←`regWrAddr`, `wb_regWrite`←`regWrite`.
  - Latency 1 cycle.
- **IDLE, `acc`=1:**
  - `stall`=1; state→ACCESS.
  - `dmem_req`←1, `dmem_we`←`memWrite`&~`memRead`.
  - `dmem_addr`←{`aLUOut`[31:2],2'b00}, `dmem_wdata`←`read_data2`.
  - `wb_regWrite`←0 (bubble).
- **ACCESS:**
  - `stall`=1; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata` held stable until ack.
  - Each non-ack cycle inserts a bubble (`wb_regWrite`←0).
  - On `dmem_ack`=1: latch `dmem_rdata`, `dmem_req`←0, state→DONE.
- **DONE:**
  - `stall`=0, so EX/MEM advances at the next edge.
  - Same edge: `wb_data`←(`memtoReg` ? latched rdata : `aLUOut`), `wb_regWrAddr`←`regWrAddr`, `wb_regWrite`←`regWrite`.
  - state→IDLE.
- **Load timing:** a load with zero-wait ack completes in 3 cycles (IDLE→ACCESS→DONE), i.e. 2 stall cycles.
- **`dmem_ack` outside ACCESS:** ignored.
- **`stall`:** combinational: (IDLE & `acc`) | ACCESS.
- **Misaligned addresses:** `aLUOut`[1:0]≠0 → low bits dropped; no trap.
- **Back-to-back accesses:** after DONE, IDLE samples the new EX/MEM contents immediately. Each access re-enters ACCESS; minimum 3 cycles per memory op.
- **Store write-back:** `wb_regWrite` follows `regWrite` (0 for legal stores).

Optional Feature:
- **Macro:** `MEM_TIMEOUT_EN`.
- **Defined:**
  - Counter clears on entry to ACCESS and increments per ACCESS cycle without ack.
  - When it reaches `TIMEOUT`: `dmem_req`←0, latched rdata←32'hDEADBEEF, `mem_err`←1 (sticky until reset), state→DONE.
  - In that DONE, `wb_regWrite`←0.
- **Undefined:**
  - ACCESS waits indefinitely.
  - `mem_err` is constant 0; no counter logic.

Test Plan:
1. Reset=0 for 2 cycles mid-ACCESS, then release → all outputs 0, state IDLE, `stall`=0; late `dmem_ack` ignored.
2. ALU op `aLUOut`=32'h0000_1234, `regWrAddr`=5, `regWrite`=1, no mem → `stall` never high; next edge `wb_data`=32'h1234, `wb_regWrAddr`=5, `wb_regWrite`=1.
3. Load `aLUOut`=32'h0000_0104, `memtoReg`=1, `regWrAddr`=8; ack after 3 cycles with rdata=32'hCAFE_F00D → `dmem_addr`=32'h104, `dmem_we`=0; `stall` high 4 cycles; then `wb_data`=32'hCAFEF00D, `wb_regWrite`=1.
4. Store `aLUOut`=32'h0000_0203, `read_data2`=32'hA5A5_A5A5, zero-wait ack → `dmem_addr`=32'h200, `dmem_we`=1, `dmem_wdata`=32'hA5A5A5A5; `stall` 2 cycles; `wb_regWrite`=0.
5. Load followed immediately by store, both zero-wait → two separate requests; EX/MEM held; 6 cycles total; no dropped or duplicated `dmem_req`.
6. With `MEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack → `dmem_req` drops after 4 ACCESS cycles; `mem_err`=1 and stays high; `wb_regWrite`=0.
